// File: rtl/counter_arb_pkg.sv
// Shared types for the counter arbiter: requester op codes and arbitration FSM states.
package counter_arb_pkg;

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_DEC  = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans requesters starting one past last_idx, wrapping, and
// returns a one-hot grant (all zero when nobody requests).
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_idx,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last_idx) + i) % NUM_REQ;
            if (!found && req[IDW'(idx)]) begin
                grant[IDW'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Shared counter serving NUM_REQ requesters through a round-robin arbiter with lock.
// Build option: COUNTER_ARB_SATURATE_EN makes INC/DEC saturate instead of wrapping.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][1:0]         req_op,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_lock,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [WIDTH-1:0]                rsp_count,
    output logic                            rsp_ovf,
    output logic                            rsp_unf,
    output logic [WIDTH-1:0]                count
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_e             state;
    logic [IDW-1:0]     owner;
    logic [IDW-1:0]     last_idx;
    logic [IDW-1:0]     sel_idx;
    logic [NUM_REQ-1:0] rr_grant;
    logic               accept;
    op_e                sel_op;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_lock;
    logic [WIDTH-1:0]   next_count;
    logic               next_ovf;
    logic               next_unf;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req      (req_valid),
        .last_idx (last_idx),
        .grant    (rr_grant)
    );

    // Grant depends only on valids and FSM state; a locked owner is the sole candidate.
    always_comb begin
        req_ready = '0;
        if (state == ARB) begin
            req_ready = rr_grant;
        end else if (req_valid[owner]) begin
            req_ready[owner] = 1'b1;
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_idx = IDW'(i);
            end
        end
    end

    // Ready is only ever raised toward a valid requester, so any ready bit is an acceptance.
    assign accept   = |req_ready;
    assign sel_op   = op_e'(req_op[sel_idx]);
    assign sel_data = req_data[sel_idx];
    assign sel_lock = req_lock[sel_idx];

    always_comb begin
        next_count = count;
        next_ovf   = 1'b0;
        next_unf   = 1'b0;
        case (sel_op)
            OP_INC: begin
                if (count == CNT_MAX) begin
                    next_ovf = 1'b1;
`ifdef COUNTER_ARB_SATURATE_EN
                    next_count = CNT_MAX;
`else
                    next_count = '0;
`endif
                end else begin
                    next_count = count + WIDTH'(1);
                end
            end
            OP_DEC: begin
                if (count == '0) begin
                    next_unf = 1'b1;
`ifdef COUNTER_ARB_SATURATE_EN
                    next_count = '0;
`else
                    next_count = CNT_MAX;
`endif
                end else begin
                    next_count = count - WIDTH'(1);
                end
            end
            OP_LOAD: next_count = sel_data;
            OP_READ: next_count = count;
            default: next_count = count;
        endcase
    end

    // Reset pointer at NUM_REQ-1 so the first search begins at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            owner     <= '0;
            last_idx  <= IDW'(NUM_REQ - 1);
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_count <= '0;
            rsp_ovf   <= 1'b0;
            rsp_unf   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                count     <= next_count;
                rsp_id    <= sel_idx;
                rsp_count <= next_count;
                rsp_ovf   <= next_ovf;
                rsp_unf   <= next_unf;
                last_idx  <= sel_idx;
            end
            case (state)
                ARB: begin
                    if (accept && sel_lock) begin
                        state <= LOCKED;
                        owner <= sel_idx;
                    end
                end
                LOCKED: begin
                    if (!req_valid[owner] || (accept && !sel_lock)) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bit width of the shared counter.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_op  input  NUM_REQ x 2  per-requester op: 00 INC, 01 DEC, 10 LOAD, 11 READ.
REQ-007 SHALL have port req_data  input  NUM_REQ x WIDTH  per-requester load value, used only for LOAD.
REQ-008 SHALL have port req_lock  input  NUM_REQ  keep the grant after this op.
REQ-009 SHALL have port req_ready  output  NUM_REQ  one-hot grant; op accepted when valid&ready.
REQ-010 SHALL have port rsp_valid  output  1  response strobe.
REQ-011 SHALL have port rsp_id  output  $clog2(NUM_REQ)  index of the requester that issued the responded op.
REQ-012 SHALL have port rsp_count  output  WIDTH  counter value after the op.
REQ-013 SHALL have port rsp_ovf / rsp_unf  output  1 each  the op wrapped/saturated past max / min.
REQ-014 SHALL have port count  output  WIDTH  current counter register.

Function
REQ-015 SHALL accept at most one op per cycle; req_ready SHALL be zero-or-one-hot and asserted only to a requester with req_valid high.
REQ-016 SHALL grant round-robin in ARB state: search starts at the index after the last granted requester, wrapping NUM_REQ-1 -> 0.
REQ-017 SHALL compute req_ready combinationally from req_valid and state; no valid-to-ready dependency on req_op/req_data.
REQ-018 SHALL execute an accepted op at the next posedge: INC count+1, DEC count-1, LOAD req_data, READ no change.
REQ-019 SHALL wrap INC at all-ones to 0 with rsp_ovf=1, and DEC at 0 to all-ones with rsp_unf=1; flags SHALL be 0 for LOAD and READ.
REQ-020 SHALL assert rsp_valid for exactly one cycle, the cycle after acceptance, with rsp_id/rsp_count/rsp_ovf/rsp_unf registered in the same edge.
REQ-021 SHALL sustain back-to-back ops, one per cycle, each response seeing the previous op's result.
REQ-022 SHALL implement FSM ARB -> LOCKED when the accepted op has req_lock=1, recording the owner index.
REQ-023 SHALL in LOCKED grant only the owner; LOCKED -> ARB on an accepted owner op with req_lock=0, or when the owner drops req_valid.
REQ-024 SHALL update the round-robin pointer only on acceptance, so that a locked owner is the last-granted index on return to ARB.

Reset
REQ-025 SHALL on rst asynchronously set count=0, rsp_valid=0, rsp_id=0, rsp_count=0, rsp_ovf=0, rsp_unf=0, state=ARB, and set the rr pointer so requester 0 has highest priority.
REQ-026 SHALL discard an op accepted in the cycle rst asserts; no response SHALL follow deassertion.

Configuration
REQ-027 SHALL with COUNTER_ARB_SATURATE_EN defined saturate instead of wrapping: INC at all-ones holds all-ones with rsp_ovf=1, and DEC at 0 holds 0 with rsp_unf=1; without it, REQ-019 wrap applies.

Structure
REQ-028 SHALL place the op enum (OP_INC, OP_DEC, OP_LOAD, OP_READ) and the FSM state enum (ARB, LOCKED) in package counter_arb_pkg.
REQ-029 SHALL instantiate one sub-module rr_arbiter (request vector + pointer -> one-hot grant), parameterised by NUM_REQ.

Verification
REQ-030 SHALL cover the following scenario: all 4 req_valid high with INC from count=0 -> grants 0,1,2,3,0 on consecutive cycles; rsp_count 1,2,3,4,5.
REQ-031 SHALL cover the following scenario: requester 2 issues LOAD 4'hF, then INC -> rsp_count F then 0 with rsp_ovf=1 (saturate build: F with rsp_ovf=1).
REQ-032 SHALL cover the following scenario: DEC at count=0 -> rsp_count F, rsp_unf=1 (saturate build: 0, rsp_unf=1).
REQ-033 SHALL cover the following scenario: requester 1 issues INC with lock=1 for 3 ops while requester 3 is valid -> requester 3 is not granted until requester 1 issues a lock=0 op; then requester 3 is granted next.
REQ-034 SHALL cover the following scenario: rst pulses mid-stream after an op is accepted -> count=0 immediately, no rsp_valid after release, and requester 0 is granted first.
